usb_spi_master: RTL and testbench

- Avalon-MM slave hardware serializer for the USB controller's serial port.
- Replaces CPU bit-banging of the SCK/SDO/CS PIO lines: the Nios writes a byte, and the block shifts it out on usb_sck/usb_sdo while capturing usb_sdi.
- Sits between the Avalon fabric (upstream) and the USB controller pins (downstream).
- SPI mode 0, MSB first, 8-bit frames, programmable SCK rate.

---
 rtl/usb_spi_master_if.sv | 20 ++
 rtl/usb_spi_master.sv | 169 ++++++++++++++++
 tb/tb_usb_spi_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_spi_master_if.sv
// Avalon-MM slave bundle for the USB serial-port serializer.
// The master modport belongs to the fabric (or a bench), the slave modport to the block.
interface usb_spi_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/usb_spi_master.sv
// Hardware SPI serializer (mode 0, MSB first, 8-bit frames) for the USB
// controller pins, replacing CPU bit-banging over PIO.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transfer; usb_sck low, busy low
// LOW   | usb_sck low half-period, usb_sdo holds the current bit
// HIGH  | usb_sck high half-period; at its end sdi is sampled and shifted
module usb_spi_master #(
  parameter logic [7:0] DIV_DEFAULT = 8'd3,
  parameter logic       CS_DEFAULT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  usb_spi_master_if.slave  avs,
  output logic             usb_sck,
  output logic             usb_sdo,
  input  logic             usb_sdi,
  output logic             usb_cs_n
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_div;
  logic [7:0]  r_div_act;
  logic [7:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rxdata;
  logic [2:0]  r_bit;
  logic        r_cs;
  logic        r_ie;
  logic        r_ovr;
  logic        r_rrdy;
  logic        r_sdo;
  logic        r_sdi_s1;
  logic        r_sdi_s2;

  logic        w_wr;
  logic        w_rd;
  logic        w_tx_wr;
  logic        w_busy;
  logic        w_cnt_tc;
  logic        w_start;
  logic        w_shift;
  logic        w_done;
  logic        w_unused;

  assign w_wr     = avs.chipselect & ~avs.write_n;
  assign w_rd     = avs.chipselect &  avs.write_n;
  assign w_tx_wr  = w_wr && (avs.address == 2'd0);
  assign w_busy   = (r_state != IDLE);
  assign w_cnt_tc = (r_cnt == 8'd0);
  assign w_unused = &{1'b0, avs.writedata[31:10]};

  assign usb_sck  = (r_state == HIGH);
  assign usb_sdo  = r_sdo;
  assign usb_cs_n = ~r_cs;
  assign avs.irq  = r_rrdy & r_ie;

  // Register read mux; decoded from address alone so reads are zero-wait.
  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      2'd1:    avs.readdata = {24'd0, r_rxdata};
      2'd2:    avs.readdata = {29'd0, r_ovr, r_rrdy, w_busy};
      2'd3:    avs.readdata = {22'd0, r_ie, r_cs, r_div};
      default: avs.readdata = 32'd0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sdi_s1 <= 1'b0;
      r_sdi_s2 <= 1'b0;
    end else begin
      r_sdi_s1 <= usb_sdi;
      r_sdi_s2 <= r_sdi_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state and phase-event decode; a half-phase ends when the down-counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tx_wr) begin
          w_state_nxt = LOW;
          w_start     = 1'b1;
        end
      end
      LOW: begin
        if (w_cnt_tc) w_state_nxt = HIGH;
      end
      HIGH: begin
        if (w_cnt_tc) begin
          w_shift = 1'b1;
          if (r_bit == 3'd7) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = LOW;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift datapath: half-period counter, shifter, bit counter, output bit, received byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_act <= DIV_DEFAULT;
      r_cnt     <= 8'd0;
      r_shift   <= 8'd0;
      r_bit     <= 3'd0;
      r_sdo     <= 1'b0;
      r_rxdata  <= 8'd0;
    end else if (w_start) begin
      // DIV is latched here so CONTROL writes mid-frame only affect the next frame.
      r_div_act <= r_div;
      r_cnt     <= r_div;
      r_shift   <= avs.writedata[7:0];
      r_bit     <= 3'd0;
      r_sdo     <= avs.writedata[7];
    end else if (w_busy) begin
      r_cnt <= w_cnt_tc ? r_div_act : (r_cnt - 8'd1);
      if (w_shift) begin
        r_shift <= {r_shift[6:0], r_sdi_s2};
        r_bit   <= r_bit + 3'd1;
        if (w_done) r_rxdata <= {r_shift[6:0], r_sdi_s2};
        else        r_sdo    <= r_shift[6];
      end
    end
  end

  // Control/status registers; completion setting rrdy wins over a same-cycle RXDATA read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= DIV_DEFAULT;
      r_cs   <= CS_DEFAULT;
      r_ie   <= 1'b0;
      r_ovr  <= 1'b0;
      r_rrdy <= 1'b0;
    end else begin
      if (w_wr && (avs.address == 2'd3)) begin
        r_div <= avs.writedata[7:0];
        r_cs  <= avs.writedata[8];
        r_ie  <= avs.writedata[9];
      end
      if (w_tx_wr && w_busy)                     r_ovr <= 1'b1;
      else if (w_wr && (avs.address == 2'd2))    r_ovr <= 1'b0;
      if (w_done)                                r_rrdy <= 1'b1;
      else if (w_rd && (avs.address == 2'd1))    r_rrdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_spi_master.sv
// Self-checking bench for usb_spi_master: randomized frames checked against a
// frame-level reference (expected bits, busy length, received byte).
module tb_usb_spi_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic usb_sck, usb_sdo, usb_sdi, usb_cs_n;

  usb_spi_master_if bus ();

  usb_spi_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .usb_sck  (usb_sck),
    .usb_sdo  (usb_sdo),
    .usb_sdi  (usb_sdi),
    .usb_cs_n (usb_cs_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor and mode-0 slave: records sdo at each SCK rise and the length
  // of every SCK high/low run; the slave presents bit (7-k) after k SCK falls.
  logic       loopback = 1'b1;
  logic [7:0] slv_byte = 8'd0;
  int         slv_base = 0;
  logic       slv_sdi  = 1'b0;
  logic       prev_sck = 1'b0;
  int         run      = 0;
  logic       q_sdo[$];
  int         hi_q[$];
  int         lo_q[$];

  assign usb_sdi = loopback ? usb_sdo : slv_sdi;

  always @(negedge clk) begin
    int k;
    if (usb_sck !== prev_sck) begin
      if (prev_sck) hi_q.push_back(run);
      else begin
        lo_q.push_back(run);
        q_sdo.push_back(usb_sdo);
      end
      run = 0;
    end
    run++;
    prev_sck = usb_sck;
    k = hi_q.size() - slv_base;
    slv_sdi = (k >= 0 && k < 8) ? slv_byte[3'(7 - k)] : 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic cur_cs = 1'b0;
  logic cur_ie = 1'b0;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 d = bus.readdata;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.address = 2'd2;
  endtask

  task automatic set_ctrl(input int div);
    wr(2'd3, {22'd0, cur_ie, cur_cs, 8'(div)});
  endtask

  // Counts negedges with STATUS.busy set; returns at the first idle negedge.
  task automatic wait_idle(input string tag, output int nbusy);
    logic seen_idle;
    nbusy = 0;
    seen_idle = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (bus.readdata[0]) nbusy++;
      else begin
        seen_idle = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(seen_idle), 32'd1);
  endtask

  function automatic logic [7:0] sdo_byte(input int base);
    logic [7:0] b = 8'hxx;
    for (int i = 0; i < 8; i++)
      b = (base + i < q_sdo.size()) ? {b[6:0], q_sdo[base + i]} : {b[6:0], 1'bx};
    return b;
  endfunction

  function automatic int bad_halves(input int hb, input int lb, input int half);
    int bad = 0;
    for (int i = 0; i < 8; i++)
      if (hb + i >= hi_q.size() || hi_q[hb + i] != half) bad++;
    for (int i = 1; i < 8; i++)
      if (lb + i >= lo_q.size() || lo_q[lb + i] != half) bad++;
    return bad;
  endfunction

  task automatic snap(input logic lb, input logic [7:0] sb,
                      output int hb, output int lbase, output int sbase);
    hb = hi_q.size(); lbase = lo_q.size(); sbase = q_sdo.size();
    loopback = lb; slv_byte = sb; slv_base = hb;
  endtask

  // One complete frame checked against the frame-level reference.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input logic lb,
                      input int div, input string tag);
    int hb, lbase, sbase, nb;
    logic [31:0] d;
    logic [7:0]  exp_rx;
    set_ctrl(div);
    snap(lb, sb, hb, lbase, sbase);
    exp_rx = lb ? tx : sb;
    wr(2'd0, {24'd0, tx});
    wait_idle(tag, nb);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(16 * (div + 1)));
    @(negedge clk); #1;
    check({tag, "_pulses"}, 32'(q_sdo.size() - sbase), 32'd8);
    check({tag, "_sdo_bits"}, {24'd0, sdo_byte(sbase)}, {24'd0, tx});
    check({tag, "_half_periods"}, 32'(bad_halves(hb, lbase, div + 1)), 32'd0);
    check({tag, "_status_done"}, bus.readdata, 32'h2);
    rd(2'd1, d);
    if (div >= 2) check({tag, "_rxdata"}, d, {24'd0, exp_rx});
    @(negedge clk); #1;
    check({tag, "_status_cleared"}, bus.readdata, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int hb, lbase, sbase, nb;

    bus.address = 2'd2; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    @(negedge clk);
    bus.address = 2'd3; #1 check("rst_control", bus.readdata, 32'h003);
    bus.address = 2'd2; #1 check("rst_status", bus.readdata, 32'h0);
    bus.address = 2'd1; #1 check("rst_rxdata", bus.readdata, 32'h0);
    bus.address = 2'd2;
    check("rst_cs_n", 32'(usb_cs_n), 32'd1);
    check("rst_sck", 32'(usb_sck), 32'd0);
    check("rst_sdo", 32'(usb_sdo), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);

    xfer(8'hA5, 8'h00, 1'b1, 3, "loop_a5");
    xfer(8'hFF, 8'h3C, 1'b0, 2, "slave_3c");

    for (int i = 0; i < 6; i++)
      xfer(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(2, 6)), "rand");

    xfer(8'h6D, 8'h00, 1'b1, 0, "div0");

    cur_cs = 1'b1;
    set_ctrl(3);
    @(negedge clk); #1 check("cs_asserted", 32'(usb_cs_n), 32'd0);

    // Second TXDATA write while busy is dropped and flags overrun.
    set_ctrl(2);
    snap(1'b1, 8'h00, hb, lbase, sbase);
    wr(2'd0, 32'h11);
    repeat (8) @(negedge clk);
    wr(2'd0, 32'h22);
    wait_idle("ovr", nb);
    @(negedge clk); #1;
    check("ovr_status", bus.readdata, 32'h6);
    check("ovr_pulses", 32'(q_sdo.size() - sbase), 32'd8);
    check("ovr_sdo_bits", {24'd0, sdo_byte(sbase)}, 32'h11);
    wr(2'd2, 32'h0);
    @(negedge clk); #1 check("ovr_cleared", bus.readdata, 32'h2);
    rd(2'd1, d);
    check("ovr_rxdata", d, 32'h11);

    // Interrupt follows rrdy & ie.
    cur_ie = 1'b1;
    set_ctrl(3);
    snap(1'b1, 8'h00, hb, lbase, sbase);
    wr(2'd0, 32'h5A);
    wait_idle("irq", nb);
    check("irq_at_done", 32'(bus.irq), 32'd1);
    rd(2'd1, d);
    check("irq_rxdata", d, 32'h5A);
    @(negedge clk); #1 check("irq_after_read", 32'(bus.irq), 32'd0);

    // RXDATA read on the completion edge: set wins.
    wr(2'd0, 32'h33);
    repeat (63) @(negedge clk);
    rd(2'd1, d);
    @(negedge clk); #1;
    check("irq_read_collide", 32'(bus.irq), 32'd1);
    check("status_read_collide", bus.readdata, 32'h2);
    rd(2'd1, d);
    check("rx_read_collide", d, 32'h33);
    @(negedge clk); #1 check("irq_cleared", 32'(bus.irq), 32'd0);

    // TXDATA on the completion edge is an overrun; the next cycle is accepted.
    cur_ie = 1'b0;
    set_ctrl(3);
    wr(2'd0, 32'h44);
    repeat (63) @(negedge clk);
    wr(2'd0, 32'h99);
    snap(1'b1, 8'h00, hb, lbase, sbase);
    wr(2'd0, 32'h66);
    @(negedge clk); #1 check("edge_status", bus.readdata, 32'h7);
    wait_idle("edge", nb);
    check("edge_busy_rest", 32'(nb), 32'd63);
    @(negedge clk); #1;
    check("edge_sdo_bits", {24'd0, sdo_byte(sbase)}, 32'h66);
    rd(2'd1, d);
    check("edge_rxdata", d, 32'h66);
    wr(2'd2, 32'h0);

    // Reset in the middle of a frame.
    cur_cs = 1'b1;
    set_ctrl(3);
    wr(2'd0, 32'hC3);
    repeat (22) @(negedge clk);
    check("pre_rst_sck", 32'(usb_sck), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_sck", 32'(usb_sck), 32'd0);
    check("midrst_cs_n", 32'(usb_cs_n), 32'd1);
    bus.address = 2'd2; #1 check("midrst_status", bus.readdata, 32'h0);
    bus.address = 2'd1; #1 check("midrst_rxdata", bus.readdata, 32'h0);
    bus.address = 2'd2;
    @(negedge clk);
    reset_n = 1'b1;
    cur_cs = 1'b0;
    xfer(8'h96, 8'h00, 1'b1, 3, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
